// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction-fetch stage with the IF/ID pipeline register.
// Owns the PC, runs a single-outstanding-request imem handshake, honours
// STALL from the hazard unit and PCSRC redirects from the branch logic.
// A capture that lands while stalled is parked in a one-entry skid register.
// Optional macro FETCH_PERF_CNT_EN adds saturating FETCH_CNT / STALL_CNT outputs.
module fetch_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = 32'h0000_0033
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             STALL,
    input  logic             PCSRC,
    input  logic [WIDTH-1:0] BRANCH_TARGET,
    output logic             IMEM_REQ,
    output logic [WIDTH-1:0] IMEM_ADDR,
    input  logic             IMEM_READY,
    input  logic [WIDTH-1:0] IMEM_RDATA,
    output logic             IFID_VALID,
    output logic [WIDTH-1:0] IFID_PC,
    output logic [WIDTH-1:0] IFID_INSTRUCTION
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      FETCH_CNT,
    output logic [31:0]      STALL_CNT
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] drain_addr;   // address of the request still in flight after a redirect
    logic [WIDTH-1:0] skid;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target;

    assign pc_plus4 = pc + WIDTH'(4);
    assign target   = {BRANCH_TARGET[WIDTH-1:2], 2'b00};

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic; a redirect overrides stall and capture decisions
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  next_state = FETCH;
            FETCH: begin
                if (PCSRC)                    next_state = IMEM_READY ? FETCH : DRAIN;
                else if (IMEM_READY && STALL) next_state = HOLD;
            end
            HOLD:  if (PCSRC || !STALL) next_state = FETCH;
            DRAIN: if (IMEM_READY) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; DRAIN keeps presenting the abandoned address until it completes
    always_comb begin
        IMEM_REQ  = (state == FETCH) || (state == DRAIN);
        IMEM_ADDR = (state == DRAIN) ? drain_addr : pc;
    end

    // PC, skid and IF/ID register updates
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc               <= RESET_PC;
            drain_addr       <= RESET_PC;
            skid             <= '0;
            IFID_VALID       <= 1'b0;
            IFID_PC          <= '0;
            IFID_INSTRUCTION <= NOP_INSTR;
        end else if (PCSRC) begin
            // In DRAIN the in-flight address is kept; only the target is replaced
            if (state == FETCH) drain_addr <= pc;
            pc               <= target;
            skid             <= '0;
            IFID_VALID       <= 1'b0;
            IFID_PC          <= '0;
            IFID_INSTRUCTION <= NOP_INSTR;
        end else begin
            case (state)
                FETCH: begin
                    if (IMEM_READY) begin
                        if (!STALL) begin
                            IFID_VALID       <= 1'b1;
                            IFID_PC          <= pc;
                            IFID_INSTRUCTION <= IMEM_RDATA;
                            pc               <= pc_plus4;
                        end else begin
                            skid <= IMEM_RDATA;
                        end
                    end else if (!STALL) begin
                        // Decode advances but nothing arrived: hand it a bubble
                        IFID_VALID       <= 1'b0;
                        IFID_PC          <= '0;
                        IFID_INSTRUCTION <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!STALL) begin
                        IFID_VALID       <= 1'b1;
                        IFID_PC          <= pc;
                        IFID_INSTRUCTION <= skid;
                        pc               <= pc_plus4;
                        skid             <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc, stall_inc;

    assign fetch_inc = !PCSRC && !STALL &&
                       (((state == FETCH) && IMEM_READY) || (state == HOLD));
    assign stall_inc = STALL || (state == DRAIN);

    // Saturating performance counters
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            FETCH_CNT <= '0;
            STALL_CNT <= '0;
        end else begin
            if (fetch_inc && (FETCH_CNT != 32'hFFFF_FFFF)) FETCH_CNT <= FETCH_CNT + 32'd1;
            if (stall_inc && (STALL_CNT != 32'hFFFF_FFFF)) STALL_CNT <= STALL_CNT + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the single-issue RV32 pipeline; feeds the decode/control stage.
- Owns the PC and drives a single-outstanding-request instruction-memory handshake.
- Honours STALL from the hazard unit and PCSRC redirects from the branch logic.
- Flushes insert a bubble encoding that decode treats as harmless.

Parameters:
- WIDTH, 32, datapath, PC and instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0033, bubble encoding (add x0,x0,x0); decodes as register write to x0 only.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- STALL  input  1  hold IF/ID contents and PC.
- PCSRC  input  1  redirect request (taken branch), one-cycle pulse.
- BRANCH_TARGET  input  WIDTH  redirect address; bits [1:0] ignored (forced 0).
- IMEM_REQ  output  1  fetch request valid.
- IMEM_ADDR  output  WIDTH  fetch address, word-aligned.
- IMEM_READY  input  1  memory response valid this cycle.
- IMEM_RDATA  input  WIDTH  instruction; valid only when IMEM_READY=1.
- IFID_VALID  output  1  IF/ID holds a real instruction.
- IFID_PC  output  WIDTH  PC of the IF/ID instruction.
- IFID_INSTRUCTION  output  WIDTH  instruction to decode; NOP_INSTR when not valid.

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_PC, IMEM_REQ=0, IMEM_ADDR=RESET_PC.
  - IFID_VALID=0, IFID_PC=0, IFID_INSTRUCTION=NOP_INSTR.
  - Skid buffer empty; state IDLE.
- Handshake:
  - IMEM_REQ high → IMEM_ADDR stable until the cycle IMEM_READY=1.
  - Transfer occurs when IMEM_REQ & IMEM_READY.
  - Max one outstanding request; IMEM_READY while IMEM_REQ=0 is ignored.
- States:
  - IDLE: one cycle after reset release → FETCH.
  - FETCH: IMEM_REQ=1, IMEM_ADDR=PC.
    - On transfer with STALL=0: IF/ID←{1,PC,RDATA}; PC←PC+4; stay FETCH.
    - On transfer with STALL=1: RDATA→skid, IMEM_REQ=0 next cycle → HOLD.
  - HOLD: IMEM_REQ=0; IF/ID frozen.
    - When STALL=0: IF/ID←skid; PC←PC+4; skid cleared → FETCH.
  - DRAIN: redirect arrived while a request was pending.
    - IMEM_REQ stays high at the old address until READY; data discarded.
    - Then → FETCH at the new PC.
- Throughput/latency: with IMEM_READY tied high, one instruction per cycle. Instruction at address A appears on IF/ID the edge after A is presented.
- STALL=1 in FETCH with no transfer: keep requesting; IF/ID unchanged.
- Redirect (PCSRC=1) has priority over STALL and over any capture:
  - PC←{BRANCH_TARGET[WIDTH-1:2],2'b00}.
  - IF/ID←{0,0,NOP_INSTR}; skid cleared.
  - FETCH with READY the same cycle: response discarded → FETCH.
  - FETCH without READY: → DRAIN.
  - HOLD or IDLE: → FETCH.
  - PCSRC in DRAIN: target overwritten; latest target wins.
- Arithmetic: PC+4 wraps modulo 2^WIDTH (32'hFFFF_FFFC → 0), no flag.
- Reset mid-transaction: everything returns to reset values immediately; a memory response arriving after release is ignored (IMEM_REQ=0 in IDLE).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs FETCH_CNT [31:0] and STALL_CNT [31:0].
  - FETCH_CNT: +1 per instruction written valid into IF/ID.
  - STALL_CNT: +1 per cycle with STALL=1 or in DRAIN.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
1. Reset then READY=1, STALL=0 → IMEM_ADDR 0,4,8,12 on consecutive cycles; IFID_PC follows one cycle later with IFID_VALID=1.
2. READY low 3 cycles at addr 8 → IMEM_ADDR held at 8, IMEM_REQ=1 throughout. On READY, IFID_PC=8; next address 12.
3. Transfer at addr 4 with STALL=1 for 2 cycles → IMEM_REQ=0 during HOLD, IF/ID frozen. After STALL drops, IFID_PC=4 next edge, then fetch at 8.
4. PCSRC=1, target 0x103 while request at 0x20 pending (READY=0) → IF/ID=NOP_INSTR, VALID=0. Addr 0x20 held until READY, data dropped. Next IMEM_ADDR=0x100.
5. PC=32'hFFFF_FFFC, READY=1 → next IMEM_ADDR=0.
6. RST_N low mid-DRAIN → all outputs at reset values asynchronously. After release, IMEM_ADDR=RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.
